// File: rtl/rib_arb.sv
`default_nettype none
// ============================================================================
//  Module      : rib_arb
//  Description : Round-robin bus arbiter with hold limit and slave decode.
//  Revision    : 1.0 - initial release
// ============================================================================
module rib_arb #(
    parameter int NUM_M    = 3,
    parameter int NUM_S    = 5,
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int SEL_W    = 4,
    parameter int MAX_HOLD = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_M-1:0]         m_req,
    input  logic [NUM_M-1:0]         m_we,
    input  logic [NUM_M*ADDR_W-1:0]  m_addr,
    input  logic [NUM_M*DATA_W-1:0]  m_wdata,
    output logic [NUM_M*DATA_W-1:0]  m_rdata,
    output logic [NUM_M-1:0]         m_gnt,
    output logic [NUM_M-1:0]         m_hold,
    output logic [NUM_S-1:0]         s_we,
    output logic [ADDR_W-1:0]        s_addr,
    output logic [DATA_W-1:0]        s_wdata,
    input  logic [NUM_S*DATA_W-1:0]  s_rdata,
    output logic                     dec_err
);

    localparam int OW       = (NUM_M > 2) ? 2 : 1;
    localparam int CNT_W    = (MAX_HOLD > 2) ? $clog2(MAX_HOLD) : 1;
    localparam int HOLD_LIM = (MAX_HOLD > 0) ? MAX_HOLD - 1 : 0;
    localparam int CMP_W    = SEL_W + 4;

    localparam logic [0:0]       c_idle     = 1'b0;
    localparam logic [0:0]       c_own      = 1'b1;
    localparam logic [CNT_W-1:0] c_hold_lim = CNT_W'(HOLD_LIM);
    localparam logic             c_hold_en  = (MAX_HOLD != 0);
    localparam logic [CMP_W-1:0] c_num_s    = CMP_W'(NUM_S);

    logic [0:0]       state_q,   state_d;
    logic [OW-1:0]    owner_q,   owner_d;
    logic [OW-1:0]    ptr_q,     ptr_d;
    logic [CNT_W-1:0] cnt_q,     cnt_d;
    logic             dec_err_q, dec_err_d;

    logic              w_own;
    logic              w_owner_req;
    logic              w_owner_we;
    logic [ADDR_W-1:0] w_owner_addr;
    logic [DATA_W-1:0] w_owner_wdata;
    logic [DATA_W-1:0] w_slave_rdata;
    logic [SEL_W-1:0]  w_sel;
    logic              w_sel_ok;
    logic              w_access;
    logic              w_limit;
    logic [OW:0]       w_pick;

    // Returns {found, index} of the first set mask bit after base, wrapping.
    function automatic logic [OW:0] rr_pick(input logic [OW-1:0] base,
                                            input logic [NUM_M-1:0] mask);
        logic found;
        int   j;
        rr_pick = '0;
        found   = 1'b0;
        for (int k = 1; k <= NUM_M; k++) begin
            j = (int'(base) + k) % NUM_M;
            if (!found && mask[j]) begin
                found   = 1'b1;
                rr_pick = {1'b1, OW'(j)};
            end
        end
    endfunction

    assign w_own = (state_q == c_own);

    always_comb begin
        w_owner_req   = 1'b0;
        w_owner_we    = 1'b0;
        w_owner_addr  = '0;
        w_owner_wdata = '0;
        m_gnt         = '0;
        for (int i = 0; i < NUM_M; i++) begin
            if (w_own && (owner_q == OW'(i))) begin
                m_gnt[i]      = 1'b1;
                w_owner_req   = m_req[i];
                w_owner_we    = m_we[i];
                w_owner_addr  = m_addr[i*ADDR_W +: ADDR_W];
                w_owner_wdata = m_wdata[i*DATA_W +: DATA_W];
            end
        end
    end

    assign w_sel    = w_owner_addr[ADDR_W-1 -: SEL_W];
    assign w_sel_ok = ({4'b0000, w_sel} < c_num_s);
    assign w_access = w_own & w_owner_req;
    assign m_hold   = m_req & ~m_gnt;
    assign s_addr   = w_owner_addr;
    assign s_wdata  = w_owner_wdata;
    assign dec_err  = dec_err_q;

    // Unmapped select values match no slave, so strobes drop out naturally.
    always_comb begin
        s_we          = '0;
        w_slave_rdata = '0;
        for (int k = 0; k < NUM_S; k++) begin
            if (w_sel == SEL_W'(k)) begin
                s_we[k]       = w_access & w_owner_we;
                w_slave_rdata = s_rdata[k*DATA_W +: DATA_W];
            end
        end
    end

    always_comb begin
        m_rdata = '0;
        for (int i = 0; i < NUM_M; i++) begin
            if (m_gnt[i] && w_sel_ok) begin
                m_rdata[i*DATA_W +: DATA_W] = w_slave_rdata;
            end
        end
    end

    assign w_limit = c_hold_en & (cnt_q == c_hold_lim) & (|m_hold);

    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        ptr_d     = ptr_q;
        cnt_d     = cnt_q;
        dec_err_d = w_access & ~w_sel_ok;
        w_pick    = '0;
        case (state_q)
            c_idle: begin
                w_pick = rr_pick(ptr_q, m_req);
                if (w_pick[OW]) begin
                    state_d = c_own;
                    owner_d = w_pick[OW-1:0];
                    cnt_d   = '0;
                end
            end
            c_own: begin
                if (!w_owner_req || w_limit) begin
                    ptr_d  = owner_q;
                    cnt_d  = '0;
                    w_pick = rr_pick(owner_q, m_hold);
                    if (w_pick[OW]) begin
                        owner_d = w_pick[OW-1:0];
                    end else begin
                        state_d = c_idle;
                    end
                end else if (c_hold_en && (cnt_q != c_hold_lim)) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = c_idle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= c_idle;
            owner_q   <= '0;
            ptr_q     <= OW'(NUM_M - 1);
            cnt_q     <= '0;
            dec_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            ptr_q     <= ptr_d;
            cnt_q     <= cnt_d;
            dec_err_q <= dec_err_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_rib_arb.sv
`default_nettype none
// ============================================================================
//  Module      : tb_rib_arb
//  Description : Directed self-checking bench for rib_arb (MAX_HOLD = 4).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_rib_arb;

    logic         clk;
    logic         rst;
    logic [2:0]   m_req;
    logic [2:0]   m_we;
    logic [95:0]  m_addr;
    logic [95:0]  m_wdata;
    logic [95:0]  m_rdata;
    logic [2:0]   m_gnt;
    logic [2:0]   m_hold;
    logic [4:0]   s_we;
    logic [31:0]  s_addr;
    logic [31:0]  s_wdata;
    logic [159:0] s_rdata;
    logic         dec_err;

    int vectors;
    int miscompares;

    rib_arb #(
        .NUM_M(3), .NUM_S(5), .ADDR_W(32), .DATA_W(32), .SEL_W(4), .MAX_HOLD(4)
    ) dut (
        .clk(clk), .rst(rst), .m_req(m_req), .m_we(m_we), .m_addr(m_addr),
        .m_wdata(m_wdata), .m_rdata(m_rdata), .m_gnt(m_gnt), .m_hold(m_hold),
        .s_we(s_we), .s_addr(s_addr), .s_wdata(s_wdata), .s_rdata(s_rdata),
        .dec_err(dec_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst     = 1'b1;
        m_req   = '0;
        m_we    = '0;
        m_addr  = '0;
        m_wdata = '0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst     = 1'b1;
        m_req   = 3'b111;
        m_we    = 3'b111;
        m_addr  = {32'h1000_0000, 32'h1000_0000, 32'h1000_0000};
        m_wdata = '0;
        s_rdata = {32'h5555, 32'h4444, 32'h3333, 32'h2222, 32'h1111};
        tick();
        tick();
        #1;
        vectors++;
        if (m_gnt !== 3'b000) begin
            miscompares++;
            $display("FAIL reset_gnt: got %b expected %b", m_gnt, 3'b000);
        end
        vectors++;
        if (m_hold !== 3'b111) begin
            miscompares++;
            $display("FAIL reset_hold: got %b expected %b", m_hold, 3'b111);
        end
        vectors++;
        if (s_we !== 5'b00000 || s_addr !== 32'h0 || dec_err !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_bus: s_we %b s_addr %h dec_err %b expected 00000 0 0",
                     s_we, s_addr, dec_err);
        end
    endtask

    task automatic test_write();
        rst     = 1'b0;
        m_req   = 3'b001;
        m_we    = 3'b001;
        m_addr  = {32'h0, 32'h0, 32'h1000_0004};
        m_wdata = {32'h0, 32'h0, 32'h0000_00A5};
        #1;
        vectors++;
        if (m_gnt !== 3'b000 || s_we !== 5'b00000) begin
            miscompares++;
            $display("FAIL write_pregrant: gnt %b s_we %b expected 000 00000", m_gnt, s_we);
        end
        tick();
        vectors++;
        if (m_gnt !== 3'b001) begin
            miscompares++;
            $display("FAIL write_gnt: got %b expected %b", m_gnt, 3'b001);
        end
        vectors++;
        if (s_we !== 5'b00010 || s_addr !== 32'h1000_0004 || s_wdata !== 32'hA5) begin
            miscompares++;
            $display("FAIL write_bus: s_we %b s_addr %h s_wdata %h expected 00010 10000004 a5",
                     s_we, s_addr, s_wdata);
        end
        m_req = 3'b000;
        #1;
        vectors++;
        if (s_we !== 5'b00000) begin
            miscompares++;
            $display("FAIL write_noreq_we: got %b expected %b", s_we, 5'b00000);
        end
        tick();
        vectors++;
        if (m_gnt !== 3'b000) begin
            miscompares++;
            $display("FAIL write_release: got %b expected %b", m_gnt, 3'b000);
        end
    endtask

    task automatic test_back_to_back();
        logic [2:0] exp_gnt  [3];
        logic [2:0] exp_hold [3];
        exp_gnt  = '{3'b001, 3'b010, 3'b100};
        exp_hold = '{3'b110, 3'b100, 3'b000};
        apply_reset();
        m_req  = 3'b111;
        m_addr = {32'h3000_0000, 32'h2000_0000, 32'h1000_0000};
        tick();
        for (int e = 0; e < 3; e++) begin
            vectors++;
            if (m_gnt !== exp_gnt[e] || m_hold !== exp_hold[e]) begin
                miscompares++;
                $display("FAIL rr_first[%0d]: gnt %b hold %b expected %b %b",
                         e, m_gnt, m_hold, exp_gnt[e], exp_hold[e]);
            end
            tick();
            vectors++;
            if (m_gnt !== exp_gnt[e]) begin
                miscompares++;
                $display("FAIL rr_second[%0d]: got %b expected %b", e, m_gnt, exp_gnt[e]);
            end
            m_req[e] = 1'b0;
            tick();
        end
        vectors++;
        if (m_gnt !== 3'b000) begin
            miscompares++;
            $display("FAIL rr_idle: got %b expected %b", m_gnt, 3'b000);
        end
    endtask

    task automatic test_hold_limit();
        apply_reset();
        m_req  = 3'b011;
        m_addr = {32'h0, 32'h1000_0000, 32'h1000_0000};
        tick();
        for (int c = 0; c < 4; c++) begin
            vectors++;
            if (m_gnt !== 3'b001) begin
                miscompares++;
                $display("FAIL hold_m0[%0d]: got %b expected %b", c, m_gnt, 3'b001);
            end
            tick();
        end
        for (int c = 0; c < 4; c++) begin
            vectors++;
            if (m_gnt !== 3'b010 || m_hold !== 3'b001) begin
                miscompares++;
                $display("FAIL hold_m1[%0d]: gnt %b hold %b expected 010 001", c, m_gnt, m_hold);
            end
            tick();
        end
        // Master 0 regains, now alone: ownership must persist past the limit.
        m_req = 3'b001;
        for (int c = 0; c < 8; c++) begin
            vectors++;
            if (m_gnt !== 3'b001) begin
                miscompares++;
                $display("FAIL hold_sat[%0d]: got %b expected %b", c, m_gnt, 3'b001);
            end
            tick();
        end
        m_req = 3'b011;
        tick();
        vectors++;
        if (m_gnt !== 3'b010) begin
            miscompares++;
            $display("FAIL hold_sat_revoke: got %b expected %b", m_gnt, 3'b010);
        end
    endtask

    task automatic test_read();
        apply_reset();
        m_req   = 3'b100;
        m_we    = 3'b000;
        m_addr  = {32'h2000_0000, 32'h0, 32'h0};
        s_rdata = {32'h5555, 32'h4444, 32'h1234, 32'h2222, 32'h1111};
        tick();
        vectors++;
        if (m_gnt !== 3'b100) begin
            miscompares++;
            $display("FAIL read_gnt: got %b expected %b", m_gnt, 3'b100);
        end
        vectors++;
        if (m_rdata !== {32'h1234, 32'h0, 32'h0}) begin
            miscompares++;
            $display("FAIL read_data: got %h expected %h", m_rdata, {32'h1234, 32'h0, 32'h0});
        end
        vectors++;
        if (s_we !== 5'b00000 || s_addr !== 32'h2000_0000) begin
            miscompares++;
            $display("FAIL read_bus: s_we %b s_addr %h expected 00000 20000000", s_we, s_addr);
        end
    endtask

    task automatic test_dec_err();
        m_we   = 3'b100;
        m_addr = {32'hF000_0000, 32'h0, 32'h0};
        #1;
        vectors++;
        if (s_we !== 5'b00000 || m_rdata !== 96'h0 || dec_err !== 1'b0) begin
            miscompares++;
            $display("FAIL decerr_access: s_we %b rdata %h dec_err %b expected 00000 0 0",
                     s_we, m_rdata, dec_err);
        end
        tick();
        m_addr = {32'h2000_0000, 32'h0, 32'h0};
        vectors++;
        if (dec_err !== 1'b1) begin
            miscompares++;
            $display("FAIL decerr_pulse: got %b expected %b", dec_err, 1'b1);
        end
        tick();
        vectors++;
        if (dec_err !== 1'b0) begin
            miscompares++;
            $display("FAIL decerr_clear: got %b expected %b", dec_err, 1'b0);
        end
    endtask

    task automatic test_reset_mid();
        #1;
        vectors++;
        if (s_we !== 5'b00100) begin
            miscompares++;
            $display("FAIL midrst_pre_we: got %b expected %b", s_we, 5'b00100);
        end
        rst = 1'b1;
        tick();
        vectors++;
        if (m_gnt !== 3'b000 || s_we !== 5'b00000) begin
            miscompares++;
            $display("FAIL midrst_abort: gnt %b s_we %b expected 000 00000", m_gnt, s_we);
        end
        rst   = 1'b0;
        m_req = 3'b110;
        tick();
        vectors++;
        if (m_gnt !== 3'b010) begin
            miscompares++;
            $display("FAIL midrst_first: got %b expected %b", m_gnt, 3'b010);
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst         = 1'b1;
        m_req       = '0;
        m_we        = '0;
        m_addr      = '0;
        m_wdata     = '0;
        s_rdata     = '0;
        test_reset();
        test_write();
        test_back_to_back();
        test_hold_limit();
        test_read();
        test_dec_err();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/rib_arb.md
RIB_ARB -- requirements
Module: rib_arb

Interface
REQ-001 Parameter NUM_M, default 3: number of bus masters, legal range 2..4.
REQ-002 Parameter NUM_S, default 5: number of slaves, legal range 1..8.
REQ-003 Parameter ADDR_W, default 32: address width.
REQ-004 Parameter DATA_W, default 32: data width.
REQ-005 Parameter SEL_W, default 4: width of slave-select field, taken as addr[ADDR_W-1 -: SEL_W].
REQ-006 Parameter MAX_HOLD, default 16: maximum consecutive owned cycles while another master waits; 0 disables the limit.
REQ-007 clk  input  1  sole clock; all state updates on its rising edge.
REQ-008 rst  input  1  reset; one clock, reset is synchronous and active-high.
REQ-009 m_req  input  NUM_M  per-master access request.
REQ-010 m_we  input  NUM_M  per-master write enable; 0 means read.
REQ-011 m_addr  input  NUM_M*ADDR_W  per-master address; master i occupies slice i.
REQ-012 m_wdata  input  NUM_M*DATA_W  per-master write data.
REQ-013 m_rdata  output  NUM_M*DATA_W  per-master read data.
REQ-014 m_gnt  output  NUM_M  one-hot-or-zero registered grant.
REQ-015 m_hold  output  NUM_M  stall indication, m_req[i] & ~m_gnt[i].
REQ-016 s_we  output  NUM_S  per-slave write strobe.
REQ-017 s_addr  output  ADDR_W  address broadcast to all slaves.
REQ-018 s_wdata  output  DATA_W  write data broadcast to all slaves.
REQ-019 s_rdata  input  NUM_S*DATA_W  per-slave combinational read data.
REQ-020 dec_err  output  1  registered one-cycle pulse on an access to an unmapped slave index.

Function
REQ-021 States: IDLE (no owner) and OWN (owner index o, m_gnt = 1<<o).
REQ-022 IDLE, any m_req: next cycle OWN with owner = first requester in round-robin order starting at ptr+1 mod NUM_M.
REQ-023 Grant is registered: a request first seen in cycle N is granted in cycle N+1.
REQ-024 Access occurs only in cycles where m_req[o] & m_gnt[o].
REQ-025 s_addr and s_wdata follow the owner's slice; they are 0 when no owner.
REQ-026 s_we[k] = m_we[o] & m_req[o] & (sel == k), where sel is the select field of the owner's address.
REQ-027 m_rdata[o] = s_rdata[sel]; m_rdata of every non-owner, and of the owner when sel >= NUM_S, is 0.
REQ-028 sel >= NUM_S during an access: all s_we are 0, and dec_err is 1 in the following cycle.
REQ-029 Owner deasserts m_req: the owner is released next cycle; ptr = o; go to the next requester by RR with no idle cycle, else IDLE.
REQ-030 Hold counter counts owned cycles; it is cleared on every ownership change.
REQ-031 Counter reaching MAX_HOLD-1 while another master requests: ownership transfers to the next RR requester in the next cycle; ptr = o.
REQ-032 Counter reaching MAX_HOLD-1 with no other requester: ownership is kept and the counter saturates.
REQ-033 With MAX_HOLD = 0, ownership is never revoked.
REQ-034 m_we and m_addr may change during ownership; each cycle is an independent single-cycle access.
REQ-035 m_gnt never has more than one bit set; at most one s_we bit is asserted per cycle.

Reset
REQ-036 rst high: state IDLE, m_gnt = 0, ptr = NUM_M-1 (so master 0 is first in RR order), hold counter = 0, dec_err = 0.
REQ-037 Reset high during OWN aborts ownership at that edge; no s_we is asserted in the cycle after that edge.

Verification
REQ-038 Reset release, m_req = 3'b001, m_we = 1, addr 0x1000_0004, data 0xA5 -> m_gnt = 001 one cycle later; s_we = 00010, s_addr = 0x1000_0004, s_wdata = 0xA5.
REQ-039 m_req = 3'b111 from IDLE, each master holding req for 2 cycles -> grant order 0, 1, 2 with no idle cycles between owners.
REQ-040 MAX_HOLD = 4, master 0 holds req while master 1 requests -> m_gnt = 001 for exactly 4 cycles, then 010; m_hold[0] = 1 afterwards.
REQ-041 Read by master 2 of addr 0x2000_0000, s_rdata slice 2 = 0x1234 -> m_rdata[2] = 0x1234; other m_rdata slices = 0.
REQ-042 Write to addr 0xF000_0000 with NUM_S = 5 -> all s_we = 0; dec_err = 1 for one cycle; m_rdata = 0.
REQ-043 rst asserted mid-ownership -> m_gnt = 0 next cycle; after release, m_req = 3'b110 -> master 1 granted first.
